// File: rtl/serial_divu_issue_unit.sv
// Multi-cycle unsigned divide unit: small in-order request FIFO feeding a
// 32-iteration restoring divider, with results held under a done/ack handshake.
module serial_divu_issue_unit #(
    parameter int ID_W  = 3,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            possible_issue,
    input  logic            new_request,
    input  logic [ID_W-1:0] id,
    input  logic [31:0]     rs1,
    input  logic [31:0]     rs2,
    input  logic [2:0]      fn3,
    output logic            wb_done,
    output logic [ID_W-1:0] wb_id,
    output logic [31:0]     wb_rd,
    input  logic            wb_ack,
    output logic [1:0]      dbg_state
);

    // Handshakes: a request transfers on an edge where new_request & ready;
    // a result transfers on an edge where wb_done & wb_ack. ready never
    // depends on new_request, and wb_done never depends on wb_ack.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ID_W + 65;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [ENT_W-1:0] fifo_q [DEPTH];
    logic [ENT_W-1:0] fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q, state_d;
    logic [4:0]       iter_q, iter_d;
    logic [31:0]      quo_q, quo_d;
    logic [32:0]      rem_q, rem_d;
    logic [31:0]      div_q, div_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rem_sel_q, rem_sel_d;

    logic             push;
    logic             pop;
    logic [32:0]      trial;
    logic [ENT_W-1:0] head;

    assign ready = ~rst & (count_q != CNT_W'(DEPTH));
    assign push  = new_request & ready;
    assign pop   = (state_q == IDLE) & (count_q != '0);
    assign head  = fifo_q[rd_ptr_q];

    // Entry layout: {id, rs1, rs2, rem_sel}.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {id, rs1, rs2, fn3[1]};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        id_d      = id_q;
        rem_sel_d = rem_sel_q;
        trial     = {rem_q[31:0], quo_q[31]} - {1'b0, div_q};
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    id_d      = head[ENT_W-1:65];
                    quo_d     = head[64:33];
                    div_d     = head[32:1];
                    rem_sel_d = head[0];
                    rem_d     = '0;
                    iter_d    = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Restore by simply not committing a negative trial difference.
                if (!trial[32]) begin
                    rem_d = trial;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[31:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (iter_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + 5'd1;
                end
            end
            DONE: begin
                if (wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload registers carry no control meaning, so they skip reset.
    always_ff @(posedge clk) begin
        fifo_q    <= fifo_d;
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        div_q     <= div_d;
        id_q      <= id_d;
        rem_sel_q <= rem_sel_d;
    end

    assign wb_done   = (state_q == DONE);
    assign wb_id     = id_q;
    assign wb_rd     = rem_sel_q ? rem_q[31:0] : quo_q;
    assign dbg_state = state_q;

    // rem_q[32] is always 0 once committed; possible_issue is advisory only.
    logic unused_ok;
    assign unused_ok = ^{possible_issue, fn3[2], fn3[0], rem_q[32]};

endmodule

// File: tb/tb_serial_divu_issue_unit.sv
// Self-checking bench for serial_divu_issue_unit: directed handshake/timing
// cases plus randomized operands against a plain-arithmetic divide model.
module tb_serial_divu_issue_unit;

    localparam int ID_W  = 3;
    localparam int DEPTH = 2;
    localparam int N_RAND = 1200;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;

    logic            clk;
    logic            rst;
    logic            ready;
    logic            possible_issue;
    logic            new_request;
    logic [ID_W-1:0] id;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [2:0]      fn3;
    logic            wb_done;
    logic [ID_W-1:0] wb_id;
    logic [31:0]     wb_rd;
    logic            wb_ack;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = 0;
    bit done_seen = 0;
    bit mon_busy = 0;
    int hold_override [8];
    logic [ID_W+31:0] exp_q [$];

    serial_divu_issue_unit #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ready(ready), .possible_issue(possible_issue),
        .new_request(new_request), .id(id), .rs1(rs1), .rs2(rs2), .fn3(fn3),
        .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: RISC-V DIVU/REMU semantics including divide-by-zero.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] f);
        if (f[1]) return (b == 0) ? a : a % b;
        else      return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    // driver tasks (called at a negedge)
    task automatic send_exp(input logic [ID_W-1:0] i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input logic [31:0] e);
        int w;
        w = 0;
        while (!ready) begin
            @(negedge clk);
            w++;
            if (w > 300) begin
                check_eq("ready_timeout", 0, 1);
                return;
            end
        end
        new_request = 1'b1;
        possible_issue = 1'b1;
        id = i; rs1 = a; rs2 = b; fn3 = f;
        exp_q.push_back({i, e});
        @(negedge clk);
        new_request = 1'b0;
        possible_issue = 1'b0;
        req_cyc = cyc;
    endtask

    task automatic send(input logic [ID_W-1:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f);
        send_exp(i, a, b, f, ref_result(a, b, f));
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!done_seen) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                check_eq(tag, 0, 1);
                return;
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int w;
        w = 0;
        while (exp_q.size() != 0 || mon_busy) begin
            @(negedge clk);
            w++;
            if (w > max_cyc) begin
                check_eq("drain_timeout", 0, 1);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        new_request = 1'b0;
        wb_ack = 1'b0;
        @(negedge clk);
        check_eq("ready_in_rst", ready, 0);
        repeat (n - 1) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        done_seen = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", ready, 1);
        check_eq("done_after_rst", wb_done, 0);
        check_eq("state_after_rst", dbg_state, ST_IDLE);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit any;
        any = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (wb_done) any = 1'b1;
        end
        check_eq(tag, any, 0);
        check_eq({tag, "_ready"}, ready, 1);
    endtask

    // scoreboard / writeback responder
    always begin : mon
        int dly;
        bit aborted;
        logic [ID_W-1:0] sid;
        logic [31:0] srd;
        logic [ID_W+31:0] e;
        @(negedge clk);
        if (!rst && wb_done) begin
            mon_busy = 1'b1;
            done_cyc = cyc;
            done_seen = 1'b1;
            sid = wb_id;
            srd = wb_rd;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
                e = {sid, srd};
            end else begin
                e = exp_q.pop_front();
            end
            check_eq("wb_id", sid, e[ID_W+31:32]);
            check_eq("wb_rd", srd, e[31:0]);
            dly = (hold_override[sid] >= 0) ? hold_override[sid] : int'($urandom_range(0, 5));
            aborted = 1'b0;
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                check_eq("hold_done", wb_done, 1);
                check_eq("hold_id", wb_id, sid);
                check_eq("hold_rd", wb_rd, srd);
            end
            if (!aborted) begin
                wb_ack = 1'b1;
                @(negedge clk);
                wb_ack = 1'b0;
                if (!rst) check_eq("done_drop", wb_done, 0);
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0] f;
        int mode;
        foreach (hold_override[i]) hold_override[i] = -1;
        rst = 1'b1; new_request = 1'b0; possible_issue = 1'b0; wb_ack = 1'b0;
        id = '0; rs1 = '0; rs2 = '0; fn3 = '0;
        repeat (2) @(negedge clk);

        // 1: reset and single DIVU with a 3-cycle ack hold
        do_reset(3);
        hold_override[5] = 3;
        send_exp(3'd5, 32'd100, 32'd7, 3'b000, 32'd14);
        wait_done("t1_done_timeout");
        check_eq("t1_latency", done_cyc - req_cyc, 33);
        drain(200);
        hold_override[5] = -1;

        // 2: REMU, divide-by-zero, max dividend; stray ack while BUSY
        done_seen = 1'b0;
        send_exp(3'd1, 32'd100, 32'd7, 3'b010, 32'd2);
        repeat (5) @(negedge clk);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        check_eq("t2_stray_ack_state", dbg_state, ST_BUSY);
        wait_done("t2_done_timeout");
        check_eq("t2_latency", done_cyc - req_cyc, 33);
        drain(200);
        send_exp(3'd2, 32'h1234_5678, 32'd0, 3'b000, 32'hFFFF_FFFF);
        send_exp(3'd3, 32'h1234_5678, 32'd0, 3'b010, 32'h1234_5678);
        drain(200);
        send_exp(3'd4, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'hFFFF_FFFF);
        drain(200);

        // 3: FIFO fill and ordering, long hold on id 2
        hold_override[2] = 10;
        send(3'd1, $urandom, $urandom_range(1, 1000), 3'b000);
        send(3'd2, $urandom, $urandom_range(1, 1000), 3'b010);
        send(3'd3, $urandom, $urandom_range(1, 1000), 3'b000);
        check_eq("t3_ready_full", ready, 0);
        check_eq("t3_state", dbg_state, ST_BUSY);
        send(3'd4, $urandom, $urandom_range(1, 1000), 3'b010);
        drain(400);
        hold_override[2] = -1;

        // 4: push on the same edge as a pop (FIFO holds 1, FSM IDLE)
        hold_override[6] = 8;
        send(3'd6, $urandom, $urandom_range(1, 50), 3'b000);
        send(3'd7, $urandom, $urandom_range(1, 50), 3'b010);
        begin : wait_idle
            int w;
            w = 0;
            while (dbg_state != ST_IDLE && w < 200) begin
                @(negedge clk);
                w++;
            end
        end
        check_eq("t4_idle_reached", dbg_state, ST_IDLE);
        check_eq("t4_ready_idle", ready, 1);
        send(3'd0, $urandom, $urandom_range(1, 50), 3'b000);
        check_eq("t4_ready_after", ready, 1);
        check_eq("t4_state_after", dbg_state, ST_BUSY);
        send(3'd1, $urandom, $urandom_range(1, 50), 3'b010);
        check_eq("t4_ready_full", ready, 0);
        drain(400);
        hold_override[6] = -1;

        // 5a: reset mid-BUSY with one entry buffered
        send(3'd3, $urandom, $urandom_range(1, 50), 3'b000);
        send(3'd4, $urandom, $urandom_range(1, 50), 3'b000);
        repeat (9) @(negedge clk);
        check_eq("t5_busy_before_rst", dbg_state, ST_BUSY);
        do_reset(2);
        expect_quiet("t5_quiet_busy", 80);
        done_seen = 1'b0;
        send(3'd2, $urandom, $urandom_range(1, 5000), 3'b010);
        wait_done("t5_done_timeout");
        check_eq("t5_latency", done_cyc - req_cyc, 33);
        drain(200);

        // 5b: reset mid-DONE
        hold_override[1] = 30;
        done_seen = 1'b0;
        send(3'd1, $urandom, $urandom_range(1, 5000), 3'b000);
        wait_done("t5b_done_timeout");
        repeat (2) @(negedge clk);
        do_reset(2);
        expect_quiet("t5_quiet_done", 80);
        hold_override[1] = -1;

        // 6: random regression
        for (int n = 0; n < N_RAND; n++) begin
            a = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(2, 255);
                4: b = a;
                5: b = a >> $urandom_range(1, 31);
                default: b = $urandom;
            endcase
            f = 3'($urandom_range(0, 7));
            send(3'($urandom_range(0, 7)), a, b, f);
        end
        drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
